// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-style control FSM: states, opcode/funct
// values, ALU operations and datapath mux selects. MC_ADDI_EN adds ADDI dispatch.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_JAL    = 4'd10,
    S_JR     = 4'd11,
    S_IMMEXE = 4'd12,
    S_IMMWB  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_XOR   = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;
  localparam logic [2:0] ALU_PASSA = 3'd4;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // Target of the DECODE dispatch; S_FETCH doubles as "unsupported opcode".
  function automatic state_e dispatch_state(input logic [5:0] opcode, input logic [5:0] funct);
    state_e st;
    case (opcode)
      OP_LW, OP_SW: st = S_MEMADR;
      OP_RTYPE:     st = (funct == FN_JR) ? S_JR : S_RTEXE;
      OP_BNE:       st = S_BRANCH;
      OP_J:         st = S_JUMP;
      OP_JAL:       st = S_JAL;
      OP_XORI:      st = S_IMMEXE;
`ifdef MC_ADDI_EN
      OP_ADDI:      st = S_IMMEXE;
`endif
      default:      st = S_FETCH;
    endcase
    return st;
  endfunction

  function automatic logic rtype_funct_ok(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for multicycle_control; only RTEXE/IMMEXE/DECODE look at
// funct/opcode. Write enables and illegal are held low while reset is high.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        reset_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        i_or_d_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_src_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        zero_ext_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o
);

  logic pc_write_s, pc_write_cond_s, i_or_d_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;

  always_comb begin
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    illegal_s       = 1'b0;
    alu_src_a_o     = SRCA_PC;
    alu_src_b_o     = SRCB_B;
    pc_src_o        = PCSRC_ALU;
    reg_dst_o       = REGDST_RT;
    mem_to_reg_o    = M2R_ALUOUT;
    zero_ext_o      = 1'b0;
    alu_op_o        = ALU_ADD;
    case (state_i)
      S_FETCH: begin
        ir_write_s  = 1'b1;
        pc_write_s  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_BRANCH;
        illegal_s   = (dispatch_state(opcode_i, funct_i) == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMRD:  i_or_d_s = 1'b1;
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
      end
      S_RTEXE: begin
        alu_src_a_o = SRCA_A;
        illegal_s   = !rtype_funct_ok(funct_i);
        case (funct_i)
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      S_RTWB: begin
        reg_write_s = 1'b1;
        reg_dst_o   = REGDST_RD;
      end
      S_BRANCH: begin
        alu_src_a_o     = SRCA_A;
        alu_op_o        = ALU_SUB;
        pc_write_cond_s = 1'b1;
        pc_src_o        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_o   = PCSRC_JUMP;
      end
      S_JAL: begin
        reg_write_s  = 1'b1;
        reg_dst_o    = REGDST_RA;
        mem_to_reg_o = M2R_PC;
        pc_write_s   = 1'b1;
        pc_src_o     = PCSRC_JUMP;
      end
      S_JR: begin
        alu_src_a_o = SRCA_A;
        alu_op_o    = ALU_PASSA;
        pc_write_s  = 1'b1;
      end
      S_IMMEXE: begin
        alu_src_a_o = SRCA_A;
        alu_src_b_o = SRCB_IMM;
`ifdef MC_ADDI_EN
        if (opcode_i == OP_ADDI) begin
          zero_ext_o = 1'b0;
          alu_op_o   = ALU_ADD;
        end else begin
          zero_ext_o = 1'b1;
          alu_op_o   = ALU_XOR;
        end
`else
        zero_ext_o = 1'b1;
        alu_op_o   = ALU_XOR;
`endif
      end
      S_IMMWB:  reg_write_s = 1'b1;
      default:  illegal_s = 1'b0;
    endcase
  end

  assign pc_write_o      = pc_write_s      & ~reset_i;
  assign pc_write_cond_o = pc_write_cond_s & ~reset_i;
  assign i_or_d_o        = i_or_d_s        & ~reset_i;
  assign mem_write_o     = mem_write_s     & ~reset_i;
  assign ir_write_o      = ir_write_s      & ~reset_i;
  assign reg_write_o     = reg_write_s     & ~reset_i;
  assign illegal_o       = illegal_s       & ~reset_i;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM (next-state logic here, outputs in mc_output_decode).
// Define MC_ADDI_EN to accept ADDI (opcode 0x08) through IMMEXE/IMMWB.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ZeroExt,
  output logic [2:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   unused_zero_s;

  // zero is consumed by the datapath's PCWriteCond gating, not by sequencing
  assign unused_zero_s = zero;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dispatch_state(opcode, funct);
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEXE:  state_d = rtype_funct_ok(funct) ? S_RTWB : S_FETCH;
      S_IMMEXE: state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  mc_output_decode u_decode (
    .state_i         (state_q),
    .opcode_i        (opcode),
    .funct_i         (funct),
    .reset_i         (reset),
    .pc_write_o      (PCWrite),
    .pc_write_cond_o (PCWriteCond),
    .i_or_d_o        (IorD),
    .mem_write_o     (MemWrite),
    .ir_write_o      (IRWrite),
    .reg_write_o     (RegWrite),
    .alu_src_a_o     (ALUSrcA),
    .alu_src_b_o     (ALUSrcB),
    .pc_src_o        (PCSrc),
    .reg_dst_o       (RegDst),
    .mem_to_reg_o    (MemtoReg),
    .zero_ext_o      (ZeroExt),
    .alu_op_o        (ALUOp),
    .illegal_o       (illegal)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction table, random
// instruction stream against a path/control model, and reset corner cases.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, RegDst, MemtoReg;
  logic       ZeroExt;
  logic [2:0] ALUOp;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pcw, pcwc, iord, memw, irw, regw, srca;
    logic [1:0] srcb, pcsrc, regdst, m2r;
    logic       zext;
    logic [2:0] aluop;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic       ill;
  } vec_t;

  ctl_t dut_ctl;
  assign dut_ctl = {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA,
                    ALUSrcB, PCSrc, RegDst, MemtoReg, ZeroExt, ALUOp, illegal};

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .ZeroExt(ZeroExt),
    .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h05, 6'h0E, 6'h23, 6'h2B: return 1'b1;
`ifdef MC_ADDI_EN
      6'h08: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Control values a given state must show, written straight from the state descriptions.
  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (st)
      4'd0:  begin c.pcw = 1'b1; c.irw = 1'b1; c.srcb = 2'd1; end
      4'd1:  begin c.srcb = 2'd3; c.ill = !op_legal(op); end
      4'd2:  begin c.srca = 1'b1; c.srcb = 2'd2; end
      4'd3:  c.iord = 1'b1;
      4'd4:  begin c.regw = 1'b1; c.m2r = 2'd1; end
      4'd5:  begin c.memw = 1'b1; c.iord = 1'b1; end
      4'd6:  begin
        c.srca = 1'b1;
        c.aluop = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
        c.ill = !((fn == 6'h20) || (fn == 6'h22) || (fn == 6'h2A));
      end
      4'd7:  begin c.regw = 1'b1; c.regdst = 2'd1; end
      4'd8:  begin c.srca = 1'b1; c.aluop = 3'd1; c.pcwc = 1'b1; c.pcsrc = 2'd1; end
      4'd9:  begin c.pcw = 1'b1; c.pcsrc = 2'd2; end
      4'd10: begin c.regw = 1'b1; c.regdst = 2'd2; c.m2r = 2'd2; c.pcw = 1'b1; c.pcsrc = 2'd2; end
      4'd11: begin c.srca = 1'b1; c.aluop = 3'd4; c.pcw = 1'b1; end
      4'd12: begin
        c.srca = 1'b1; c.srcb = 2'd2;
        c.zext = (op == 6'h08) ? 1'b0 : 1'b1;
        c.aluop = (op == 6'h08) ? 3'd0 : 3'd2;
      end
      4'd13: c.regw = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Runs one instruction from a FETCH cycle; the expected state path comes from the instruction class.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           output int cyc, output logic ill_seen);
    logic [3:0] seq [8];
    int len;
    for (int i = 0; i < 8; i++) seq[i] = 4'd0;
    seq[1] = 4'd1;
    len = 2;
    case (op)
      6'h23: begin seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4; len = 5; end
      6'h2B: begin seq[2] = 4'd2; seq[3] = 4'd5; len = 4; end
      6'h00: begin
        if (fn == 6'h08) begin seq[2] = 4'd11; len = 3; end
        else if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin seq[2] = 4'd6; seq[3] = 4'd7; len = 4; end
        else begin seq[2] = 4'd6; len = 3; end
      end
      6'h05: begin seq[2] = 4'd8; len = 3; end
      6'h02: begin seq[2] = 4'd9; len = 3; end
      6'h03: begin seq[2] = 4'd10; len = 3; end
      6'h0E: begin seq[2] = 4'd12; seq[3] = 4'd13; len = 4; end
`ifdef MC_ADDI_EN
      6'h08: begin seq[2] = 4'd12; seq[3] = 4'd13; len = 4; end
`endif
      default: len = 2;
    endcase
    opcode = op; funct = fn; zero = z;
    #1;
    cyc = 0;
    ill_seen = 1'b0;
    do begin
      if (cyc < len) begin
        chk($sformatf("state op=%0h fn=%0h c%0d", op, fn, cyc), 32'(state), 32'(seq[cyc]));
        chk($sformatf("ctl op=%0h fn=%0h c%0d", op, fn, cyc), 32'(dut_ctl), 32'(exp_ctl(seq[cyc], op, fn)));
      end else begin
        chk($sformatf("extra_cycle op=%0h", op), 32'(cyc), 32'(len));
      end
      ill_seen = ill_seen | illegal;
      @(negedge clk);
      cyc++;
    end while (state != 4'd0 && cyc < 12);
    chk($sformatf("latency op=%0h fn=%0h", op, fn), 32'(cyc), 32'(len));
  endtask

  vec_t       vecs [15];
  logic [5:0] op_pool [12];
  logic [5:0] fn_pool [5];
  int         cyc;
  logic       ill_seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{6'h23, 6'h00, 1'b0, 5, 1'b0};
    vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4, 1'b0};
    vecs[2]  = '{6'h00, 6'h20, 1'b0, 4, 1'b0};
    vecs[3]  = '{6'h00, 6'h22, 1'b1, 4, 1'b0};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 4, 1'b0};
    vecs[5]  = '{6'h00, 6'h27, 1'b0, 3, 1'b1};
    vecs[6]  = '{6'h00, 6'h08, 1'b0, 3, 1'b0};
    vecs[7]  = '{6'h05, 6'h00, 1'b1, 3, 1'b0};
    vecs[8]  = '{6'h05, 6'h00, 1'b0, 3, 1'b0};
    vecs[9]  = '{6'h02, 6'h00, 1'b0, 3, 1'b0};
    vecs[10] = '{6'h03, 6'h00, 1'b0, 3, 1'b0};
    vecs[11] = '{6'h0E, 6'h00, 1'b0, 4, 1'b0};
`ifdef MC_ADDI_EN
    vecs[12] = '{6'h08, 6'h00, 1'b0, 4, 1'b0};
`else
    vecs[12] = '{6'h08, 6'h00, 1'b0, 2, 1'b1};
`endif
    vecs[13] = '{6'h3F, 6'h20, 1'b0, 2, 1'b1};
    vecs[14] = '{6'h04, 6'h00, 1'b1, 2, 1'b1};
    op_pool = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h05, 6'h02, 6'h03, 6'h0E, 6'h08, 6'h00, 6'h00};
    fn_pool = '{6'h08, 6'h20, 6'h22, 6'h2A, 6'h27};

    // Reset held two cycles: FETCH state, every enable and illegal low.
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("reset_state%0d", i), 32'(state), 32'd0);
      chk($sformatf("reset_enables%0d", i), 32'({PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, illegal}), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("first_fetch_state", 32'(state), 32'd0);
    chk("first_fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("first_fetch_pcwrite", 32'(PCWrite), 32'd1);

    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, cyc, ill_seen);
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_illegal", i), 32'(ill_seen), 32'(vecs[i].ill));
    end

    // Reset in MEMADR of a SW and of a LW: instruction abandoned, no write, back to FETCH.
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'h2B : 6'h23; funct = 6'h00;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("abort%0d_in_memadr", k), 32'(state), 32'd2);
      reset = 1'b1;
      #1;
      chk($sformatf("abort%0d_enables_during", k), 32'({PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, illegal}), 32'd0);
      @(negedge clk);
      chk($sformatf("abort%0d_state_after", k), 32'(state), 32'd0);
      chk($sformatf("abort%0d_no_write", k), 32'({MemWrite, RegWrite, PCWrite, IRWrite}), 32'd0);
      reset = 1'b0;
      #1;
      chk($sformatf("abort%0d_fetch_resumes", k), 32'({IRWrite, PCWrite}), 32'd3);
      run_instr(6'h00, 6'h2A, 1'b0, cyc, ill_seen);
    end

    // Random instruction stream against the model.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] rop, rfn;
      rop = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) rop = 6'($urandom);
      rfn = fn_pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) rfn = 6'($urandom);
      run_instr(rop, rfn, 1'($urandom), cyc, ill_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
